// File: rtl/sram_arb_pkg.sv
// Shared constants for the SRAM arbiter: response owner codes, FSM states
// and the default starvation limit.
package sram_arb_pkg;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] INST_RESP = 2'd1;
  localparam logic [1:0] DATA_RESP = 2'd2;

  localparam int unsigned STARVE_MAX_DEFAULT = 4;

  // The response state follows whichever side won the grant this cycle.
  function automatic logic [1:0] resp_state_next(input logic inst_win, input logic data_win);
    if (data_win)      return DATA_RESP;
    else if (inst_win) return INST_RESP;
    else               return IDLE;
  endfunction

endpackage

// File: rtl/sram_arb_starve_ctr.sv
// Saturating 4-bit counter of data grants taken while fetch waits;
// sat tells the arbiter to hand the next slot to fetch.
module sram_arb_starve_ctr
  import sram_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [3:0] MAX_V = 4'(STARVE_MAX);

  logic [3:0] cnt;

  // Clear dominates; the counter holds at MAX_V and never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (inc && cnt != MAX_V) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign sat = (cnt == MAX_V);

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch and data access;
// data wins ties unless fetch has been starved for STARVE_MAX data grants.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cancel,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds req (and its address/data) stable until it
  // sees addr_ok in the same cycle; data_ok then arrives exactly one cycle later.

  logic       inst_elig;
  logic       inst_win;
  logic       data_win;
  logic       starve_sat;
  logic [1:0] state;
  logic       resp_valid;
  logic       resp_owner;
  logic       resp_kill;
  logic       resp_wr;

  // Grants are masked while reset is high so every output reads 0 then.
  assign inst_elig = inst_req & ~inst_cancel & ~reset;
  assign data_win  = data_req & ~reset & ~(inst_elig & starve_sat);
  assign inst_win  = inst_elig & (~data_req | starve_sat);

  sram_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (data_win & inst_req),
    .clr   (inst_win | ~inst_req),
    .sat   (starve_sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      resp_kill <= 1'b0;
      resp_wr   <= 1'b0;
    end else begin
      state     <= resp_state_next(inst_win, data_win);
      resp_kill <= inst_cancel & data_win & resp_valid & (resp_owner == OWNER_INST);
      resp_wr   <= data_win & data_wr;
    end
  end

  assign resp_valid = (state != IDLE);
  assign resp_owner = (state == DATA_RESP) ? OWNER_DATA : OWNER_INST;
  assign dbg_state  = state;

  assign inst_addr_ok = inst_win;
  assign data_addr_ok = data_win;
  assign sram_en      = inst_win | data_win;
  assign sram_we      = (data_win & data_wr) ? data_wstrb : 4'd0;
  assign sram_wdata   = data_win ? data_wdata : 32'd0;
  assign sram_addr    = data_win ? data_addr : (inst_win ? inst_addr : 32'd0);

  // A cancel arriving in the response cycle drops the fetch data on the floor.
  assign inst_data_ok = resp_valid & (resp_owner == OWNER_INST) & ~inst_cancel & ~resp_kill;
  assign inst_rdata   = inst_data_ok ? sram_rdata : 32'd0;
  assign data_data_ok = resp_valid & (resp_owner == OWNER_DATA);
  assign data_rdata   = (data_data_ok & ~resp_wr) ? sram_rdata : 32'd0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: fetch, conflict, starvation, store,
// cancel and asynchronous reset scenarios with hand-computed expectations.
module tb_sram_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_cancel;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [1:0]  dbg_state;

  int checks;
  int errors;

  sram_arbiter #(.STARVE_MAX(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_cancel  (inst_cancel),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change on the falling edge, checks follow 1ns later
  task automatic drive_idle();
    inst_req    = 1'b0;
    inst_addr   = 32'd0;
    inst_cancel = 1'b0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_wstrb  = 4'd0;
    data_addr   = 32'd0;
    data_wdata  = 32'd0;
    sram_rdata  = 32'd0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive_idle();
    repeat (2) next_cycle();
    #1;
    chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    chk("rst_data_data_ok", 32'(data_data_ok), 32'd0);
    chk("rst_sram_en", 32'(sram_en), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;

    // fetch only
    next_cycle();
    inst_req = 1'b1; inst_addr = 32'h1c00_0000;
    #1;
    chk("fetch_addr_ok", 32'(inst_addr_ok), 32'd1);
    chk("fetch_sram_en", 32'(sram_en), 32'd1);
    chk("fetch_sram_addr", sram_addr, 32'h1c00_0000);
    chk("fetch_sram_we", 32'(sram_we), 32'd0);
    chk("fetch_data_addr_ok", 32'(data_addr_ok), 32'd0);
    next_cycle();
    inst_req = 1'b0; sram_rdata = 32'h0280_0c0c;
    #1;
    chk("fetch_data_ok", 32'(inst_data_ok), 32'd1);
    chk("fetch_rdata", inst_rdata, 32'h0280_0c0c);
    chk("fetch_state", 32'(dbg_state), 32'd1);
    chk("fetch_no_data_ok", 32'(data_data_ok), 32'd0);
    chk("fetch_no_data_rdata", data_rdata, 32'd0);

    // conflict: data load wins, fetch follows next cycle
    next_cycle();
    sram_rdata = 32'd0;
    inst_req = 1'b1; inst_addr = 32'h1c00_0004;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0080;
    #1;
    chk("conf_data_addr_ok", 32'(data_addr_ok), 32'd1);
    chk("conf_inst_blocked", 32'(inst_addr_ok), 32'd0);
    chk("conf_sram_addr", sram_addr, 32'h0000_0080);
    next_cycle();
    data_req = 1'b0; sram_rdata = 32'h1234_5678;
    #1;
    chk("conf_data_ok", 32'(data_data_ok), 32'd1);
    chk("conf_data_rdata", data_rdata, 32'h1234_5678);
    chk("conf_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    chk("conf_inst_sram_addr", sram_addr, 32'h1c00_0004);
    chk("conf_inst_no_data_ok", 32'(inst_data_ok), 32'd0);
    next_cycle();
    inst_req = 1'b0; sram_rdata = 32'h1111_2222;
    #1;
    chk("conf_inst_data_ok", 32'(inst_data_ok), 32'd1);
    chk("conf_inst_rdata", inst_rdata, 32'h1111_2222);
    chk("conf_data_ok_gone", 32'(data_data_ok), 32'd0);

    // starvation: four data grants then one forced fetch, repeating
    next_cycle();
    sram_rdata = 32'd0;
    inst_req = 1'b1; inst_addr = 32'h1c00_0100;
    data_req = 1'b1; data_addr = 32'h0000_0200;
    for (int k = 0; k < 10; k++) begin
      if (k != 0) next_cycle();
      #1;
      chk($sformatf("starve_inst_%0d", k), 32'(inst_addr_ok), (k % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("starve_data_%0d", k), 32'(data_addr_ok), (k % 5 == 4) ? 32'd0 : 32'd1);
    end
    next_cycle();
    drive_idle();

    // store
    next_cycle();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_addr = 32'h0000_0040; data_wdata = 32'haabb_ccdd;
    #1;
    chk("st_addr_ok", 32'(data_addr_ok), 32'd1);
    chk("st_sram_we", 32'(sram_we), 32'h3);
    chk("st_sram_addr", sram_addr, 32'h0000_0040);
    chk("st_sram_wdata", sram_wdata, 32'haabb_ccdd);
    next_cycle();
    drive_idle();
    sram_rdata = 32'hdead_beef;
    #1;
    chk("st_data_ok", 32'(data_data_ok), 32'd1);
    chk("st_rdata_zero", data_rdata, 32'd0);
    chk("st_state", 32'(dbg_state), 32'd2);

    // cancel: fetch granted, then squashed; new request blocked by cancel
    next_cycle();
    sram_rdata = 32'd0;
    inst_req = 1'b1; inst_addr = 32'h1c00_0010;
    #1;
    chk("cxl_grant", 32'(inst_addr_ok), 32'd1);
    next_cycle();
    inst_addr = 32'h1c00_0014; inst_cancel = 1'b1; sram_rdata = 32'h0000_0055;
    #1;
    chk("cxl_data_ok_squashed", 32'(inst_data_ok), 32'd0);
    chk("cxl_rdata_zero", inst_rdata, 32'd0);
    chk("cxl_new_req_blocked", 32'(inst_addr_ok), 32'd0);
    chk("cxl_sram_en", 32'(sram_en), 32'd0);
    next_cycle();
    drive_idle();
    #1;
    chk("cxl_no_late_data_ok", 32'(inst_data_ok), 32'd0);
    chk("cxl_state_idle", 32'(dbg_state), 32'd0);

    // async reset between a grant and its response
    next_cycle();
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0100;
    #1;
    chk("ar_grant", 32'(data_addr_ok), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_data_ok_during", 32'(data_data_ok), 32'd0);
    chk("ar_addr_ok_during", 32'(data_addr_ok), 32'd0);
    chk("ar_sram_en_during", 32'(sram_en), 32'd0);
    chk("ar_state_during", 32'(dbg_state), 32'd0);
    next_cycle();
    drive_idle();
    reset = 1'b0;
    sram_rdata = 32'h0000_0077;
    #1;
    chk("ar_no_data_ok_after", 32'(data_data_ok), 32'd0);
    chk("ar_rdata_after", data_rdata, 32'd0);
    next_cycle();
    #1;
    chk("ar_still_quiet", 32'(data_data_ok), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares one synchronous single-port SRAM between the instruction-fetch requester (pre-IF stage) and the data requester (MEM stage) of the 5-stage LA32R pipeline. Each side uses a req/addr_ok/data_ok handshake, and one access is granted per cycle. Read data returns one cycle after the grant. Data accesses win conflicts, and a starvation counter bounds how long fetch can be locked out. Branch-cancel squashes in-flight fetch responses.

## Interface
Parameters:
- STARVE_MAX, 4, maximum consecutive data grants while inst_req is pending before inst is forced (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_req  in  1  fetch request, held until inst_addr_ok.
- inst_addr  in  32  fetch address, word aligned.
- inst_cancel  in  1  branch-cancel; squashes the fetch in flight.
- inst_addr_ok  out  1  fetch granted this cycle.
- inst_data_ok  out  1  fetch data valid this cycle.
- inst_rdata  out  32  fetch data; 0 when inst_data_ok=0.
- data_req  in  1  data request, held until data_addr_ok.
- data_wr  in  1  1=store, 0=load.
- data_wstrb  in  4  byte strobes for stores.
- data_addr  in  32  data address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  data access granted this cycle.
- data_data_ok  out  1  load data valid or store completed.
- data_rdata  out  32  load data; 0 when data_data_ok=0 or for stores.
- sram_en  out  1  SRAM access enable.
- sram_we  out  4  SRAM byte write enables.
- sram_addr  out  32  SRAM address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_en.

## Operation
Arbitration is combinational each cycle.
- inst is eligible when inst_req=1 and inst_cancel=0.
- If both sides are eligible, data wins unless starve_cnt==STARVE_MAX, in which case inst wins.
- If only one side is eligible, it wins.

Grant outputs:
- The winner's addr_ok=1.
- sram_en=1, and sram_addr is the winner's address.
- sram_we = data_wstrb when data wins with data_wr=1, otherwise 0.
- sram_wdata = data_wdata, or 0 when inst wins.

Response tracking registers:
- resp_valid: set on any grant, cleared otherwise.
- resp_owner: 0=inst, 1=data.
- resp_kill: set when inst_cancel=1 in a cycle that grants data while an inst response is in flight. Only meaningful for inst responses.

Response outputs, in the cycle after a grant:
- Owner inst: inst_data_ok = ~inst_cancel & ~resp_kill, and inst_rdata = sram_rdata when inst_data_ok=1.
- Owner data: data_data_ok=1 unconditionally, and data_rdata = sram_rdata for loads, 0 for stores. Store-vs-load is tracked in a resp_wr register.

Starvation counter starve_cnt, width 4:
- Increments on a data grant while inst_req=1, saturating at STARVE_MAX.
- Clears on an inst grant, or whenever inst_req=0.

The FSM view of resp_valid/resp_owner has three states:
- IDLE → INST_RESP on an inst grant.
- IDLE → DATA_RESP on a data grant.
- Any state moves to the state matching the current grant, or to IDLE with no grant. Back-to-back grants are legal.

## Timing
- Reset values: all outputs 0; resp_valid=0, resp_kill=0, starve_cnt=0.
- addr_ok and the sram_* outputs are same-cycle combinational from the req inputs and registered state.
- Latency: grant in cycle N gives data_ok in cycle N+1. Sustained throughput is 1 access per cycle.
- inst_cancel in cycle N blocks an inst grant in cycle N.
- inst_cancel in cycle N+1 suppresses inst_data_ok for the cycle-N fetch.
- A data grant and a starvation-forced inst grant never occur in the same cycle.
- Simultaneous inst_cancel and inst_req=1 with data_req=0: no grant, and sram_en=0.
- Reset asserted mid-access: the in-flight response is dropped with no data_ok after reset deassertion. SRAM contents are not touched.
- Counter saturation: starve_cnt never exceeds STARVE_MAX, and it never wraps.

## Structure
- Shared package sram_arb_pkg holds:
  - owner encodings OWNER_INST=1'b0 and OWNER_DATA=1'b1;
  - FSM state localparams IDLE, INST_RESP, DATA_RESP;
  - the default STARVE_MAX=4.
- One sub-module, sram_arb_starve_ctr: a saturating counter with inc, clr and sat outputs, parameterised by STARVE_MAX.
- The top level holds the arbitration logic, response registers and output muxing.

## Test plan
- **Fetch only:** inst_req=1, addr 0x1c000000, SRAM returns 0x02800c0c → inst_addr_ok in cycle 0, inst_data_ok with inst_rdata=0x02800c0c in cycle 1, data_* outputs stay 0.
- **Conflict:** inst_req=1 and data_req=1 load at 0x80, SRAM returns 0x12345678 → data_addr_ok in cycle 0, data_data_ok with 0x12345678 in cycle 1, inst_addr_ok in cycle 1.
- **Starvation:** STARVE_MAX=4, both requesters held high continuously → 4 data grants, then 1 inst grant on the 5th cycle, then the pattern repeats.
- **Store:** data_wr=1, wstrb=4'b0011, addr 0x40, wdata 0xAABBCCDD → sram_we=4'b0011 in the same cycle, data_data_ok=1 next cycle with data_rdata=0.
- **Cancel:** inst granted in cycle 0, inst_cancel=1 in cycle 1 → inst_data_ok stays 0. A new inst_req in cycle 1 is not granted in cycle 1.
- **Async reset:** reset pulse between a grant and its response → all outputs 0 immediately, and no data_ok after reset is released.
